// File: rtl/fb_stream_writer.sv
// ============================================================================
// Module   : fb_stream_writer
// Purpose  : Raster-order frame buffer reader that feeds the write port of the
//            cross-clock display FIFO. A credit scheme bounds reads in flight
//            plus skid entries to two, so no pixel is dropped or duplicated
//            under any fifo_full pattern.
// Options  : FB_STREAM_TEST_PATTERN_EN adds pattern_sel, which selects
//            internally generated 8-bar color data instead of RAM reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_stream_writer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19,
  parameter int COLOR_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
`ifdef FB_STREAM_TEST_PATTERN_EN
  input  logic               pattern_sel,
`endif
  input  logic               fifo_full,
  output logic [COLOR_W-1:0] fifo_din,
  output logic               fifo_wr_en,
  output logic               fb_rd_en,
  output logic [ADDR_W-1:0]  fb_addr,
  input  logic [COLOR_W-1:0] fb_data,
  output logic               frame_start,
  output logic               frame_done,
  output logic               busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  localparam int               NPIX      = H_ACTIVE * V_ACTIVE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  logic [1:0]         state;
  logic [ADDR_W-1:0]  rd_addr;     // next address to issue
  logic [ADDR_W-1:0]  addr_hold;   // last driven fb_addr, held while idle
  logic [ADDR_W-1:0]  wr_idx;      // pixel index of the skid head
  logic               rd_pending;  // a read was issued last cycle
  logic [1:0]         skid_cnt;
  logic [COLOR_W-1:0] skid0;
  logic [COLOR_W-1:0] skid1;

  logic               avail;
  logic               issue;
  logic               pat_now;
  logic [2:0]         occ_next;
  logic [COLOR_W-1:0] data_in;
  logic [COLOR_W-1:0] head;

`ifdef FB_STREAM_TEST_PATTERN_EN
  localparam int BAR   = H_ACTIVE / 8;
  localparam int BAR_W = (BAR > 1) ? $clog2(BAR) : 1;
  localparam int COL_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

  logic               pat_frame;
  logic               pat_pending;
  logic [COLOR_W-1:0] pat_data;
  logic [COL_W-1:0]   col_cnt;
  logic [BAR_W-1:0]   bar_cnt;
  logic [COLOR_W-1:0] bar_idx;

  // Pattern selection is taken live on the address-0 issue, latched for the rest of the frame
  assign pat_now = (rd_addr == '0) ? pattern_sel : pat_frame;
  assign data_in = pat_pending ? pat_data : fb_data;

  // Synthesized pixel pipeline: same one-cycle latency as a RAM read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_frame   <= 1'b0;
      pat_pending <= 1'b0;
      pat_data    <= '0;
      col_cnt     <= '0;
      bar_cnt     <= '0;
      bar_idx     <= '0;
    end else begin
      pat_pending <= issue & pat_now;
      if (issue) begin
        pat_data <= bar_idx;
        if (rd_addr == '0) begin
          pat_frame <= pattern_sel;
        end
        if (col_cnt == COL_W'(H_ACTIVE - 1)) begin
          col_cnt <= '0;
          bar_cnt <= '0;
          bar_idx <= '0;
        end else begin
          col_cnt <= col_cnt + 1'b1;
          if (bar_cnt == BAR_W'(BAR - 1)) begin
            bar_cnt <= '0;
            bar_idx <= bar_idx + 1'b1;
          end else begin
            bar_cnt <= bar_cnt + 1'b1;
          end
        end
      end
    end
  end
`else
  assign pat_now = 1'b0;
  assign data_in = fb_data;
`endif

  // Skid head is the oldest stored entry, or the returning read when the skid is empty
  assign avail      = rd_pending | (skid_cnt != 2'd0);
  assign head       = (skid_cnt != 2'd0) ? skid0 : data_in;
  assign fifo_wr_en = avail & ~fifo_full;
  assign fifo_din   = avail ? head : '0;

  // Occupancy next cycle if nothing is issued now; issuing keeps it at most two
  assign occ_next = 3'(skid_cnt) + 3'(rd_pending) - 3'(fifo_wr_en);
  assign issue    = (state == S_STREAM) && (occ_next < 3'd2);

  assign fb_rd_en    = issue & ~pat_now;
  assign fb_addr     = fb_rd_en ? rd_addr : addr_hold;
  assign frame_start = issue && (rd_addr == '0);
  assign frame_done  = fifo_wr_en && (wr_idx == LAST_ADDR);
  assign busy        = (state != S_IDLE);

  // Frame sequencing; enable is only looked at in IDLE and on the last issue of a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      rd_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          rd_addr <= '0;
          if (enable) begin
            state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (issue) begin
            if (rd_addr == LAST_ADDR) begin
              rd_addr <= '0;
              if (!enable) begin
                state <= S_DRAIN;
              end
            end else begin
              rd_addr <= rd_addr + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (!rd_pending && (skid_cnt == 2'd0)) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read-in-flight flag, held address and write-side pixel index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending <= 1'b0;
      addr_hold  <= '0;
      wr_idx     <= '0;
    end else begin
      rd_pending <= issue;
      addr_hold  <= fb_addr;
      if (fifo_wr_en) begin
        wr_idx <= (wr_idx == LAST_ADDR) ? '0 : wr_idx + 1'b1;
      end
    end
  end

  // Two-entry skid: push returning data, pop on FIFO write; bypass when empty and writable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_cnt <= 2'd0;
      skid0    <= '0;
      skid1    <= '0;
    end else begin
      case ({rd_pending, fifo_wr_en})
        2'b10: begin
          if (skid_cnt == 2'd0) begin
            skid0 <= data_in;
          end else begin
            skid1 <= data_in;
          end
          skid_cnt <= skid_cnt + 2'd1;
        end
        2'b01: begin
          skid0    <= skid1;
          skid_cnt <= skid_cnt - 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            skid0 <= data_in;
          end else if (skid_cnt == 2'd2) begin
            skid0 <= skid1;
            skid1 <= data_in;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fb_stream_writer.sv
// ============================================================================
// Module   : tb_fb_stream_writer
// Purpose  : Directed self-checking bench for fb_stream_writer on a reduced
//            16x4 frame. Inputs change 1 time unit after the rising edge;
//            outputs are observed on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fb_stream_writer;

  localparam int H    = 16;
  localparam int V    = 4;
  localparam int NPIX = H * V;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        fifo_full;
  logic [2:0]  fifo_din;
  logic        fifo_wr_en;
  logic        fb_rd_en;
  logic [18:0] fb_addr;
  logic [2:0]  fb_data;
  logic        frame_start;
  logic        frame_done;
  logic        busy;
  logic        pattern_sel;
  logic        pat_mode;

  int tests = 0;
  int fails = 0;

  // Observed-stream statistics, cleared while reset is asserted
  int         wr_cnt, rd_cnt_m, data_err, full_err, fd_err, fd_cnt, fs_cnt, max_out;
  logic [2:0] cap_c2, cap_c15;

  fb_stream_writer #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .ADDR_W  (19),
    .COLOR_W (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
`ifdef FB_STREAM_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .fifo_full  (fifo_full),
    .fifo_din   (fifo_din),
    .fifo_wr_en (fifo_wr_en),
    .fb_rd_en   (fb_rd_en),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .frame_start(frame_start),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Frame buffer model: data = addr[2:0], one cycle after the read
  always @(posedge clk) fb_data <= fb_addr[2:0];

  // Stream monitor
  always @(negedge clk) begin
    int         pix;
    int         outst;
    logic [2:0] expv;
    if (!rst_n) begin
      wr_cnt = 0; rd_cnt_m = 0; data_err = 0; full_err = 0;
      fd_err = 0; fd_cnt = 0; fs_cnt = 0; max_out = 0;
      cap_c2 = 3'd0; cap_c15 = 3'd0;
    end else begin
      outst = rd_cnt_m - wr_cnt;
      if (outst > max_out) max_out = outst;
      if (fifo_wr_en && fifo_full) full_err++;
      pix = wr_cnt % NPIX;
      if (pat_mode) expv = 3'((pix % H) / (H / 8));
      else          expv = 3'(pix % 8);
      if (fifo_wr_en) begin
        if (fifo_din !== expv) data_err++;
        if (frame_done !== (pix == NPIX - 1)) fd_err++;
        if (frame_done) fd_cnt++;
        if (pix == 2)  cap_c2  = fifo_din;
        if (pix == 15) cap_c15 = fifo_din;
        wr_cnt++;
      end else if (frame_done) begin
        fd_err++;
      end
      if (fb_rd_en) rd_cnt_m++;
      if (frame_start) fs_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic apply_reset();
    rst_n = 1'b0; enable = 1'b0; fifo_full = 1'b0;
    pattern_sel = 1'b0; pat_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; fifo_full = 1'b0;
    pattern_sel = 1'b0; pat_mode = 1'b0;
    #2;
    tests++;
    if ({fifo_wr_en, fb_rd_en, frame_start, frame_done, busy} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got wr=%b rd=%b fs=%b fd=%b busy=%b, expected all 0",
               fifo_wr_en, fb_rd_en, frame_start, frame_done, busy);
    end
    tests++;
    if (fb_addr !== 19'd0 || fifo_din !== 3'd0) begin
      fails++;
      $display("FAIL reset_data: got addr=%0d din=%0d, expected 0/0", fb_addr, fifo_din);
    end
    apply_reset();
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || fb_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got busy=%b rd=%b, expected 0/0", busy, fb_rd_en);
    end
  endtask

  task automatic test_stream();
    int bad = 0;
    apply_reset();
    enable = 1'b1;
    @(negedge clk);
    tests++;
    if (fb_rd_en !== 1'b0 || fifo_wr_en !== 1'b0) begin
      fails++;
      $display("FAIL stream_idle_cycle: got rd=%b wr=%b, expected 0/0", fb_rd_en, fifo_wr_en);
    end
    @(negedge clk);
    tests++;
    if (fb_rd_en !== 1'b1 || fb_addr !== 19'd0 || frame_start !== 1'b1 ||
        fifo_wr_en !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL stream_first_read: got rd=%b addr=%0d fs=%b wr=%b busy=%b, expected 1/0/1/0/1",
               fb_rd_en, fb_addr, frame_start, fifo_wr_en, busy);
    end
    for (int i = 1; i < 2 * NPIX; i++) begin
      @(negedge clk);
      tests++;
      if (fb_rd_en !== 1'b1 || fb_addr !== 19'(i % NPIX) || frame_start !== (i % NPIX == 0) ||
          fifo_wr_en !== 1'b1 || fifo_din !== 3'((i - 1) % 8)) begin
        fails++;
        if (bad < 5)
          $display("FAIL stream_cycle_%0d: got rd=%b addr=%0d fs=%b wr=%b din=%0d, expected 1/%0d/%b/1/%0d",
                   i, fb_rd_en, fb_addr, frame_start, fifo_wr_en, fifo_din,
                   i % NPIX, (i % NPIX == 0), (i - 1) % 8);
        bad++;
      end
    end
    @(posedge clk); #1 enable = 1'b0;
    wait_idle(4 * NPIX);
    tests++;
    if (busy !== 1'b0 || wr_cnt !== 3 * NPIX) begin
      fails++;
      $display("FAIL stream_drain: got busy=%b writes=%0d, expected 0/%0d", busy, wr_cnt, 3 * NPIX);
    end
    tests++;
    if (data_err !== 0 || fd_err !== 0 || fd_cnt !== 3 || fs_cnt !== 3) begin
      fails++;
      $display("FAIL stream_stats: got data_err=%0d fd_err=%0d fd=%0d fs=%0d, expected 0/0/3/3",
               data_err, fd_err, fd_cnt, fs_cnt);
    end
    tests++;
    if (fb_addr !== 19'(NPIX - 1) || fb_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL stream_addr_hold: got addr=%0d rd=%b, expected %0d/0", fb_addr, fb_rd_en, NPIX - 1);
    end
  endtask

  task automatic test_full_toggle();
    int n = 0;
    apply_reset();
    enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    while (busy && n < 8 * NPIX) begin
      @(posedge clk); #1 fifo_full = ~fifo_full;
      n++;
    end
    fifo_full = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || wr_cnt !== NPIX || fd_cnt !== 1) begin
      fails++;
      $display("FAIL toggle_count: got busy=%b writes=%0d fd=%0d, expected 0/%0d/1", busy, wr_cnt, fd_cnt, NPIX);
    end
    tests++;
    if (data_err !== 0 || full_err !== 0 || fd_err !== 0) begin
      fails++;
      $display("FAIL toggle_integrity: got data_err=%0d full_err=%0d fd_err=%0d, expected 0/0/0",
               data_err, full_err, fd_err);
    end
    tests++;
    if (max_out > 2) begin
      fails++;
      $display("FAIL toggle_outstanding: got max=%0d, expected <= 2", max_out);
    end
  endtask

  task automatic test_full_hold();
    int n = 0;
    int rd0, wr0;
    apply_reset();
    enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    while (wr_cnt < 20 && n < 4 * NPIX) begin
      @(posedge clk); #1;
      n++;
    end
    fifo_full = 1'b1;
    rd0 = rd_cnt_m; wr0 = wr_cnt;
    repeat (50) @(posedge clk);
    #1;
    tests++;
    if (rd_cnt_m - rd0 > 2 || wr_cnt !== wr0) begin
      fails++;
      $display("FAIL hold_stall: got reads=%0d writes=%0d during hold, expected <=2/0",
               rd_cnt_m - rd0, wr_cnt - wr0);
    end
    fifo_full = 1'b0;
    @(negedge clk);
    tests++;
    if (fb_rd_en !== 1'b1 || fifo_wr_en !== 1'b1) begin
      fails++;
      $display("FAIL hold_resume: got rd=%b wr=%b, expected 1/1", fb_rd_en, fifo_wr_en);
    end
    wait_idle(4 * NPIX);
    tests++;
    if (wr_cnt !== NPIX || data_err !== 0 || full_err !== 0 || max_out > 2) begin
      fails++;
      $display("FAIL hold_integrity: got writes=%0d data_err=%0d full_err=%0d max=%0d, expected %0d/0/0/<=2",
               wr_cnt, data_err, full_err, max_out, NPIX);
    end
  endtask

  task automatic test_reset_midframe();
    apply_reset();
    enable = 1'b1;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if ({fifo_wr_en, fb_rd_en, frame_start, frame_done, busy} !== 5'b0 ||
        fb_addr !== 19'd0 || fifo_din !== 3'd0) begin
      fails++;
      $display("FAIL midreset_outputs: got wr=%b rd=%b fs=%b fd=%b busy=%b addr=%0d din=%0d, expected all 0",
               fifo_wr_en, fb_rd_en, frame_start, frame_done, busy, fb_addr, fifo_din);
    end
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (fb_rd_en !== 1'b1 || fb_addr !== 19'd0 || frame_start !== 1'b1) begin
      fails++;
      $display("FAIL midreset_restart: got rd=%b addr=%0d fs=%b, expected 1/0/1", fb_rd_en, fb_addr, frame_start);
    end
    @(posedge clk); #1 enable = 1'b0;
    wait_idle(4 * NPIX);
    tests++;
    if (wr_cnt !== NPIX || data_err !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midreset_frame: got writes=%0d data_err=%0d busy=%b, expected %0d/0/0",
               wr_cnt, data_err, busy, NPIX);
    end
  endtask

`ifdef FB_STREAM_TEST_PATTERN_EN
  task automatic test_pattern();
    apply_reset();
    pat_mode = 1'b1; pattern_sel = 1'b1; enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    @(posedge clk); #1 pattern_sel = 1'b0;
    wait_idle(4 * NPIX);
    tests++;
    if (rd_cnt_m !== 0 || wr_cnt !== NPIX || data_err !== 0) begin
      fails++;
      $display("FAIL pattern_stream: got reads=%0d writes=%0d data_err=%0d, expected 0/%0d/0",
               rd_cnt_m, wr_cnt, data_err, NPIX);
    end
    tests++;
    if (cap_c2 !== 3'd1 || cap_c15 !== 3'd7) begin
      fails++;
      $display("FAIL pattern_bars: got col2=%0d col15=%0d, expected 1/7", cap_c2, cap_c15);
    end
    tests++;
    if (fd_cnt !== 1 || fs_cnt !== 1 || fd_err !== 0) begin
      fails++;
      $display("FAIL pattern_pulses: got fd=%0d fs=%0d fd_err=%0d, expected 1/1/0", fd_cnt, fs_cnt, fd_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_full_toggle();
    test_full_hold();
    test_reset_midframe();
`ifdef FB_STREAM_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
